// File: rtl/vga_pixel_source.sv
// vga_pixel_source
// ----------------
// Produces a 640x480@60 VGA pixel stream by upscaling a small image held in
// an external ROM. The horizontal and vertical counters step on each pix_en
// tick. The stream then passes through two pipeline stages:
//   stage 1: forms the ROM address and registers the sync/active flags
//   stage 2: captures the ROM word and releases colour, syncs and active
//            together
// Total latency is two pix_en ticks. Colour, syncs and active always leave
// the block on the same tick, so they never skew against each other.
//
// Optional feature: define TEST_PATTERN_EN to add the test_mode input. When
// test_mode=1, stage 2 drives eight vertical colour bars instead of img_data.
//
// Ports
//   clk         in   system clock, all logic on its rising edge
//   rst_n       in   synchronous active-low reset
//   pix_en      in   single-cycle pixel tick; all state holds when it is 0
//   test_mode   in   (TEST_PATTERN_EN only) select the colour-bar pattern
//   img_addr    out  15-bit image ROM address, registered
//   img_data    in   ROM word {r[11:8], g[7:4], b[3:0]}
//   r, g, b     out  4-bit colour channels
//   hsync       out  active-low horizontal sync
//   vsync       out  active-low vertical sync
//   active      out  high while r/g/b carry a visible pixel
//   frame_start out  one-clk pulse when pixel (0,0) reaches the outputs
module vga_pixel_source #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SCALE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
`ifdef TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [14:0] img_addr,
  input  logic [11:0] img_data,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  // Horizontal and vertical timing of the fixed 800x525 raster.
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_LAST       = 10'd524;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);

  // Width of one image row in ROM words. This is a constant, so the
  // row * IMG_W product folds to a fixed shift-add network.
  localparam logic [14:0] IMG_W = 15'(H_ACTIVE >> SCALE_LOG2);

  // Raster counters
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;

  // Stage 1 registers
  logic [14:0] addr1_q, addr1_d;
  logic        hsync1_q, hsync1_d;
  logic        vsync1_q, vsync1_d;
  logic        active1_q, active1_d;
  logic        first1_q, first1_d;

  // Stage 2 registers (the outputs)
  logic [11:0] colour_q, colour_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;

  // Values decoded from the current counter position
  logic        visible;
  logic        hsync_raw;
  logic        vsync_raw;
  logic [14:0] row_idx;
  logic [14:0] col_idx;
  logic [14:0] addr_calc;

`ifdef TEST_PATTERN_EN
  logic [2:0]  bar1_q, bar1_d;
  logic [2:0]  bar_idx;
  logic [11:0] bar_colour;

  // Each bar is 80 pixels wide, so the bar index is the number of
  // 80-pixel boundaries the counter has passed.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt_q >= 10'(k * 80)) begin
        bar_idx = 3'(k);
      end
    end
  end

  // Bar order is white, yellow, cyan, green, magenta, red, blue, black.
  // Each channel is therefore a single (inverted) bit of the bar index.
  assign bar_colour = {{4{~bar1_q[1]}}, {4{~bar1_q[2]}}, {4{~bar1_q[0]}}};
`endif

  assign visible   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hsync_raw = !((hcnt_q >= H_SYNC_START) && (hcnt_q <= H_SYNC_END));
  assign vsync_raw = !((vcnt_q >= V_SYNC_START) && (vcnt_q <= V_SYNC_END));
  assign row_idx   = 15'(vcnt_q >> SCALE_LOG2);
  assign col_idx   = 15'(hcnt_q >> SCALE_LOG2);
  // The 15-bit context truncates the address to 15 bits.
  assign addr_calc = row_idx * IMG_W + col_idx;

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    addr1_d       = addr1_q;
    hsync1_d      = hsync1_q;
    vsync1_d      = vsync1_q;
    active1_d     = active1_q;
    first1_d      = first1_q;
    colour_d      = colour_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    // frame_start is a pulse rather than a held value. It therefore drops
    // on the clk after it was raised, even if pix_en stays low.
    frame_start_d = pix_en & first1_q;
`ifdef TEST_PATTERN_EN
    bar1_d        = bar1_q;
`endif

    if (pix_en) begin
      // Raster counters
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end

      // Stage 1: the address is only refreshed inside the visible area,
      // so the ROM is never read out of range during blanking.
      if (visible) begin
        addr1_d = addr_calc;
      end
      hsync1_d  = hsync_raw;
      vsync1_d  = vsync_raw;
      active1_d = visible;
      first1_d  = (hcnt_q == '0) && (vcnt_q == '0);
`ifdef TEST_PATTERN_EN
      bar1_d    = bar_idx;
`endif

      // Stage 2: img_data already corresponds to addr1_q
      colour_d = active1_q ? img_data : 12'h000;
`ifdef TEST_PATTERN_EN
      if (test_mode) begin
        colour_d = active1_q ? bar_colour : 12'h000;
      end
`endif
      hsync_d  = hsync1_q;
      vsync_d  = vsync1_q;
      active_d = active1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      addr1_q       <= '0;
      hsync1_q      <= 1'b1;
      vsync1_q      <= 1'b1;
      active1_q     <= 1'b0;
      first1_q      <= 1'b0;
      colour_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef TEST_PATTERN_EN
      bar1_q        <= '0;
`endif
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      addr1_q       <= addr1_d;
      hsync1_q      <= hsync1_d;
      vsync1_q      <= vsync1_d;
      active1_q     <= active1_d;
      first1_q      <= first1_d;
      colour_q      <= colour_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
`ifdef TEST_PATTERN_EN
      bar1_q        <= bar1_d;
`endif
    end
  end

  assign img_addr    = addr1_q;
  assign r           = colour_q[11:8];
  assign g           = colour_q[7:4];
  assign b           = colour_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;

endmodule
